// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: operand forwarding, load-use bubble, branch flush and memory-wait stall.
// Define HAZ_PERF_CNT_EN to add the Perf_stall_cnt / Perf_flush_cnt performance counters.
module ex_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int REG_ADDR_W   = 5
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [REG_ADDR_W-1:0] IF_Rs1_addr,
    input  logic [REG_ADDR_W-1:0] IF_Rs2_addr,
    input  logic [REG_ADDR_W-1:0] ID_Rs1_addr,
    input  logic [REG_ADDR_W-1:0] ID_Rs2_addr,
    input  logic [REG_ADDR_W-1:0] ID_Rd_addr,
    input  logic                  ID_Mem_rd_en,
    input  logic [REG_ADDR_W-1:0] EX_Rd_addr,
    input  logic                  EX_RegFile_wr_en,
    input  logic                  EX_MemToReg,
    input  logic [REG_ADDR_W-1:0] WB_Rd_addr,
    input  logic                  WB_RegFile_wr_en,
    input  logic                  EX_PC_Branch,
    input  logic                  Mem_busy,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB,
    output logic                  PC_Stall,
    output logic                  IF_Stall,
    output logic                  IF_Flush,
    output logic                  ID_Flush,
    output logic                  EX_Flush,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0]           Perf_stall_cnt,
    output logic [31:0]           Perf_flush_cnt,
`endif
    output logic [1:0]            Hazard_state
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOADUSE = 2'd1,
        FLUSH   = 2'd2,
        MEMWAIT = 2'd3
    } haz_state_e;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    haz_state_e state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       pending_q, pending_d;
    logic       ex_fwd_ok, wb_fwd_ok, load_use;
    logic       do_flush, do_wait, do_bubble;

    // x0 is hardwired, so a write to it never produces a forwardable value.
    assign ex_fwd_ok = EX_RegFile_wr_en && !EX_MemToReg && (EX_Rd_addr != '0);
    assign wb_fwd_ok = WB_RegFile_wr_en && (WB_Rd_addr != '0);

    assign ForwardA = (ex_fwd_ok && (EX_Rd_addr == ID_Rs1_addr)) ? 2'b10 :
                      (wb_fwd_ok && (WB_Rd_addr == ID_Rs1_addr)) ? 2'b01 : 2'b00;
    assign ForwardB = (ex_fwd_ok && (EX_Rd_addr == ID_Rs2_addr)) ? 2'b10 :
                      (wb_fwd_ok && (WB_Rd_addr == ID_Rs2_addr)) ? 2'b01 : 2'b00;

    assign load_use = ID_Mem_rd_en && (ID_Rd_addr != '0) &&
                      ((ID_Rd_addr == IF_Rs1_addr) || (ID_Rd_addr == IF_Rs2_addr));

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d   = RUN;
        cnt_d     = cnt_q;
        pending_d = 1'b0;
        do_flush  = 1'b0;
        do_wait   = 1'b0;
        do_bubble = 1'b0;

        case (state_q)
            FLUSH: begin
                do_flush = 1'b1;
                cnt_d    = EX_PC_Branch ? FLUSH_LOAD : cnt_q - 2'd1;
            end
            MEMWAIT: begin
                // A branch seen while memory is busy waits here and becomes the exit flush.
                if (Mem_busy) begin
                    do_wait   = 1'b1;
                    pending_d = pending_q || EX_PC_Branch;
                end else if (EX_PC_Branch || pending_q) begin
                    do_flush = 1'b1;
                    cnt_d    = FLUSH_LOAD;
                end else if (load_use) begin
                    do_bubble = 1'b1;
                end
            end
            LOADUSE: begin
                if (EX_PC_Branch) begin
                    do_flush = 1'b1;
                    cnt_d    = FLUSH_LOAD;
                end else if (Mem_busy) begin
                    do_wait = 1'b1;
                end else begin
                    do_bubble = 1'b1;
                end
            end
            default: begin
                if (EX_PC_Branch) begin
                    do_flush = 1'b1;
                    cnt_d    = FLUSH_LOAD;
                end else if (Mem_busy) begin
                    do_wait = 1'b1;
                end else if (load_use) begin
                    do_bubble = 1'b1;
                end
            end
        endcase

        // The detection cycle is the first flush cycle, so FLUSH only covers the remainder.
        if (do_flush) begin
            state_d = (cnt_d != 2'd0) ? FLUSH : RUN;
        end else if (do_wait) begin
            state_d = MEMWAIT;
        end else if (do_bubble && (state_q != LOADUSE)) begin
            state_d = LOADUSE;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= RUN;
            cnt_q     <= 2'd0;
            pending_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops sample pre-edge values together.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    // Controls are gated by reset so the stage registers see no stray stall/flush in reset.
    assign PC_Stall     = Reset_n && (do_wait || do_bubble);
    assign IF_Stall     = Reset_n && (do_wait || do_bubble);
    assign IF_Flush     = Reset_n && do_flush;
    assign ID_Flush     = Reset_n && (do_flush || do_bubble);
    assign EX_Flush     = Reset_n && do_flush;
    assign Hazard_state = state_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, PC_Stall};
        perf_flush_d = perf_flush_q + {31'd0, IF_Flush};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign Perf_stall_cnt = perf_stall_q;
    assign Perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: cycle-by-cycle model comparison plus hand-computed spot checks.
module tb_ex_hazard_ctrl;

    localparam int FC = 2;

    logic       Clk, Reset_n;
    logic [4:0] IF_Rs1_addr, IF_Rs2_addr, ID_Rs1_addr, ID_Rs2_addr, ID_Rd_addr;
    logic       ID_Mem_rd_en;
    logic [4:0] EX_Rd_addr, WB_Rd_addr;
    logic       EX_RegFile_wr_en, EX_MemToReg, WB_RegFile_wr_en;
    logic       EX_PC_Branch, Mem_busy;
    logic [1:0] ForwardA, ForwardB, Hazard_state;
    logic       PC_Stall, IF_Stall, IF_Flush, ID_Flush, EX_Flush;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] Perf_stall_cnt, Perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    ex_hazard_ctrl #(.FLUSH_CYCLES(FC), .REG_ADDR_W(5)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .IF_Rs1_addr(IF_Rs1_addr), .IF_Rs2_addr(IF_Rs2_addr),
        .ID_Rs1_addr(ID_Rs1_addr), .ID_Rs2_addr(ID_Rs2_addr),
        .ID_Rd_addr(ID_Rd_addr), .ID_Mem_rd_en(ID_Mem_rd_en),
        .EX_Rd_addr(EX_Rd_addr), .EX_RegFile_wr_en(EX_RegFile_wr_en),
        .EX_MemToReg(EX_MemToReg), .WB_Rd_addr(WB_Rd_addr),
        .WB_RegFile_wr_en(WB_RegFile_wr_en), .EX_PC_Branch(EX_PC_Branch),
        .Mem_busy(Mem_busy), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .PC_Stall(PC_Stall), .IF_Stall(IF_Stall), .IF_Flush(IF_Flush),
        .ID_Flush(ID_Flush), .EX_Flush(EX_Flush),
`ifdef HAZ_PERF_CNT_EN
        .Perf_stall_cnt(Perf_stall_cnt), .Perf_flush_cnt(Perf_flush_cnt),
`endif
        .Hazard_state(Hazard_state)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {PC_Stall, IF_Stall, IF_Flush, ID_Flush, EX_Flush}
    function automatic logic [31:0] ctl();
        return {27'd0, PC_Stall, IF_Stall, IF_Flush, ID_Flush, EX_Flush};
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (EX_RegFile_wr_en && !EX_MemToReg && EX_Rd_addr != 5'd0 && EX_Rd_addr == rs) return 2'b10;
        if (WB_RegFile_wr_en && WB_Rd_addr != 5'd0 && WB_Rd_addr == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Model: distance in cycles since the last serviced branch, plus wait/pending/bubble flags.
    int  since_br = 99;
    bit  wait_st = 0, pend = 0, lu_st = 0;
    int  m_stall_cnt = 0, m_flush_cnt = 0;

    always @(negedge Clk) begin : compare
        bit in_flush, flushing, waiting, bubble, serviced, lu;
        logic [1:0] e_state;
        lu = ID_Mem_rd_en && ID_Rd_addr != 5'd0 &&
             (ID_Rd_addr == IF_Rs1_addr || ID_Rd_addr == IF_Rs2_addr);
        check("m_fwdA", 32'(ForwardA), 32'(exp_fwd(ID_Rs1_addr)));
        check("m_fwdB", 32'(ForwardB), 32'(exp_fwd(ID_Rs2_addr)));
        if (!Reset_n) begin
            check("m_rst_ctl", ctl(), 0);
            check("m_rst_state", 32'(Hazard_state), 0);
            since_br = 99; wait_st = 0; pend = 0; lu_st = 0;
            m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            in_flush = since_br >= 1 && since_br < FC;
            e_state  = in_flush ? 2'd2 : wait_st ? 2'd3 : lu_st ? 2'd1 : 2'd0;
            flushing = 0; waiting = 0; bubble = 0; serviced = 0;
            if (in_flush) begin
                flushing = 1; serviced = EX_PC_Branch;
            end else if (wait_st && Mem_busy) begin
                waiting = 1;
            end else if (EX_PC_Branch || (wait_st && pend)) begin
                flushing = 1; serviced = 1;
            end else if (Mem_busy) begin
                waiting = 1;
            end else if (lu || lu_st) begin
                bubble = 1;
            end
            check("m_state", 32'(Hazard_state), 32'(e_state));
            check("m_ctl", ctl(), {27'd0, waiting || bubble, waiting || bubble,
                                   flushing, flushing || bubble, flushing});
`ifdef HAZ_PERF_CNT_EN
            check("m_perf_stall", Perf_stall_cnt, 32'(m_stall_cnt));
            check("m_perf_flush", Perf_flush_cnt, 32'(m_flush_cnt));
            m_stall_cnt += int'(waiting || bubble);
            m_flush_cnt += int'(flushing);
`endif
            pend     = waiting && (pend || EX_PC_Branch);
            since_br = serviced ? 1 : (since_br < 99 ? since_br + 1 : 99);
            wait_st  = waiting;
            lu_st    = bubble && !lu_st;
        end
    end

    task automatic clear_inputs();
        IF_Rs1_addr = 0; IF_Rs2_addr = 0; ID_Rs1_addr = 0; ID_Rs2_addr = 0; ID_Rd_addr = 0;
        ID_Mem_rd_en = 0; EX_Rd_addr = 0; WB_Rd_addr = 0; EX_RegFile_wr_en = 0;
        EX_MemToReg = 0; WB_RegFile_wr_en = 0; EX_PC_Branch = 0; Mem_busy = 0;
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic smp();
        @(negedge Clk);
    endtask

    initial begin
        clear_inputs();
        Reset_n = 1'b0;
        smp();
        check("reset_state", 32'(Hazard_state), 0);
        check("reset_ctl", ctl(), 0);
        #2 Reset_n = 1'b1;

        // Forwarding: EX/MEM beats WB, MemToReg blocks EX/MEM, x0 never forwards.
        cyc();
        EX_Rd_addr = 5; EX_RegFile_wr_en = 1; WB_Rd_addr = 5; WB_RegFile_wr_en = 1;
        ID_Rs1_addr = 5; ID_Rs2_addr = 5;
        smp(); check("fwdA_ex_prio", 32'(ForwardA), 2); check("fwdB_ex_prio", 32'(ForwardB), 2);
        cyc(); EX_RegFile_wr_en = 0;
        smp(); check("fwdA_wb", 32'(ForwardA), 1);
        cyc(); EX_RegFile_wr_en = 1; EX_MemToReg = 1;
        smp(); check("fwdB_memtoreg_wb", 32'(ForwardB), 1);
        cyc(); EX_MemToReg = 0; ID_Rs1_addr = 0; EX_Rd_addr = 0; WB_Rd_addr = 0; ID_Rs2_addr = 9;
        smp(); check("fwdA_x0", 32'(ForwardA), 0); check("fwdB_none", 32'(ForwardB), 0);
        cyc(); EX_Rd_addr = 3; WB_Rd_addr = 4; ID_Rs1_addr = 4; ID_Rs2_addr = 3;
        smp(); check("fwdA_split", 32'(ForwardA), 1); check("fwdB_split", 32'(ForwardB), 2);

        // Load-use bubble.
        cyc(); clear_inputs(); ID_Mem_rd_en = 1; ID_Rd_addr = 7; IF_Rs2_addr = 7; IF_Rs1_addr = 2;
        smp(); check("lu_detect", ctl(), 5'b11010); check("lu_detect_state", 32'(Hazard_state), 0);
        cyc();
        smp(); check("lu_state", 32'(Hazard_state), 1);
        cyc(); clear_inputs();
        smp(); check("lu_clear", ctl(), 0); check("lu_clear_state", 32'(Hazard_state), 0);
        cyc(); ID_Mem_rd_en = 1; ID_Rd_addr = 0; IF_Rs1_addr = 0;
        smp(); check("lu_x0", ctl(), 0);

        // Single branch pulse: two flush cycles, PC never stalled.
        cyc(); clear_inputs(); EX_PC_Branch = 1;
        smp(); check("br_detect", ctl(), 5'b00111);
        cyc(); EX_PC_Branch = 0;
        smp(); check("br_hold", ctl(), 5'b00111); check("br_state", 32'(Hazard_state), 2);
        cyc();
        smp(); check("br_done", ctl(), 0); check("br_done_state", 32'(Hazard_state), 0);

        // Branch during FLUSH reloads the counter.
        cyc(); EX_PC_Branch = 1;
        cyc();
        cyc(); EX_PC_Branch = 0;
        smp(); check("br_reload", ctl(), 5'b00111); check("br_reload_state", 32'(Hazard_state), 2);
        cyc();
        smp(); check("br_reload_done", 32'(Hazard_state), 0);

        // Branch beats busy beats load-use.
        cyc(); EX_PC_Branch = 1; Mem_busy = 1; ID_Mem_rd_en = 1; ID_Rd_addr = 7; IF_Rs1_addr = 7;
        smp(); check("prio_branch", ctl(), 5'b00111);
        cyc(); clear_inputs(); Mem_busy = 0;
        cyc();
        cyc(); Mem_busy = 1; ID_Mem_rd_en = 1; ID_Rd_addr = 7; IF_Rs1_addr = 7;
        smp(); check("prio_busy", ctl(), 5'b11000);
        cyc(); clear_inputs();
        cyc();

        // Memory wait of four cycles with a load-use during the wait.
        cyc(); Mem_busy = 1;
        smp(); check("mw_c0", ctl(), 5'b11000);
        cyc();
        smp(); check("mw_c1", ctl(), 5'b11000); check("mw_state", 32'(Hazard_state), 3);
        cyc(); ID_Mem_rd_en = 1; ID_Rd_addr = 7; IF_Rs1_addr = 7;
        smp(); check("mw_lu_no_bubble", ctl(), 5'b11000);
        cyc(); ID_Mem_rd_en = 0;
        smp(); check("mw_c3", ctl(), 5'b11000);
        cyc(); Mem_busy = 0;
        smp(); check("mw_exit", ctl(), 0);
        cyc();
        smp(); check("mw_run", 32'(Hazard_state), 0);

        // Branch while busy is held until the wait ends.
        cyc(); clear_inputs(); Mem_busy = 1;
        cyc(); EX_PC_Branch = 1;
        smp(); check("bb_pend", ctl(), 5'b11000);
        cyc(); EX_PC_Branch = 0;
        smp(); check("bb_pend2", ctl(), 5'b11000);
        cyc(); Mem_busy = 0;
        smp(); check("bb_flush1", ctl(), 5'b00111);
        cyc();
        smp(); check("bb_flush2", ctl(), 5'b00111); check("bb_flush_state", 32'(Hazard_state), 2);
        cyc();
        smp(); check("bb_done", ctl(), 0); check("bb_done_state", 32'(Hazard_state), 0);

        // Asynchronous reset in the middle of FLUSH.
        cyc(); EX_PC_Branch = 1;
        cyc(); EX_PC_Branch = 0;
        #1 check("pre_rst_state", 32'(Hazard_state), 2);
        Reset_n = 1'b0; EX_PC_Branch = 1; Mem_busy = 1;
        #1 check("rst_async_ctl", ctl(), 0); check("rst_async_state", 32'(Hazard_state), 0);
        smp();
        cyc(); EX_PC_Branch = 0; Mem_busy = 0;
        #1 Reset_n = 1'b1;
        smp(); check("post_rst_state", 32'(Hazard_state), 0); check("post_rst_ctl", ctl(), 0);
`ifdef HAZ_PERF_CNT_EN
        check("post_rst_perf_stall", Perf_stall_cnt, 0);
        check("post_rst_perf_flush", Perf_flush_cnt, 0);
`endif
        cyc();
        cyc();
        smp();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
